// File: rtl/multi_alarm_clock_core.sv
// multi_alarm_clock_core: 24-hour HH:MM timekeeper with NUM_ALARMS independent alarms,
// handshaked keypad entry with range checking, snooze and auto-timeout ringing.
// Ports:
//   clock, reset (async, active-low)
//   time_button / alarm_button : level requests for time / alarm entry
//   alarm_sel                  : alarm targeted by entry, latched when entry starts
//   alarm_enable               : per-alarm arm mask
//   fastwatch                  : selects FAST_TICKS cycles per minute
//   key, key_valid             : BCD digit and its one-cycle qualifier
//   snooze, stop_alarm         : one-cycle strobes
//   ms_hour..ls_minute         : ASCII display digits (entry buffer while entering)
//   alarm_sound, alarm_id      : ringing flag and index of the ringing alarm
//   entry_error                : one-cycle pulse on an out-of-range entry
module multi_alarm_clock_core #(
  parameter int unsigned NUM_ALARMS    = 4,
  parameter int unsigned TICKS_PER_MIN = 6000,
  parameter int unsigned FAST_TICKS    = 1,
  parameter int unsigned SNOOZE_MIN    = 5,
  parameter int unsigned RING_MIN      = 2,
  parameter int unsigned AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  time_button,
  input  logic                  alarm_button,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_enable,
  input  logic                  fastwatch,
  input  logic [3:0]            key,
  input  logic                  key_valid,
  input  logic                  snooze,
  input  logic                  stop_alarm,
  output logic [7:0]            ms_hour,
  output logic [7:0]            ls_hour,
  output logic [7:0]            ms_minute,
  output logic [7:0]            ls_minute,
  output logic                  alarm_sound,
  output logic [AW-1:0]         alarm_id,
  output logic                  entry_error
);
  localparam int unsigned MaxP = (TICKS_PER_MIN > FAST_TICKS) ? TICKS_PER_MIN : FAST_TICKS;
  localparam int unsigned CW   = $clog2(MaxP + 1);
  localparam int unsigned RCW  = $clog2(RING_MIN + 1);

  localparam logic [1:0] EntIdle  = 2'd0;
  localparam logic [1:0] EntTime  = 2'd1;
  localparam logic [1:0] EntAlarm = 2'd2;
  localparam logic [1:0] RingIdle = 2'd0;
  localparam logic [1:0] RingOn   = 2'd1;
  localparam logic [1:0] RingSnz  = 2'd2;

  logic [CW-1:0]  presc_q, presc_d, period;
  logic           tick;
  logic [4:0]     hour_q, hour_d;
  logic [5:0]     min_q, min_d;
  logic           changed_q;
  logic [4:0]     al_hour_q [NUM_ALARMS];
  logic [5:0]     al_min_q  [NUM_ALARMS];

  logic [1:0]     ent_state_q, ent_state_d;
  logic [15:0]    buf_q, buf_d, buf_shift;
  logic [1:0]     dig_cnt_q, dig_cnt_d;
  logic [AW-1:0]  ent_sel_q, ent_sel_d;
  logic [6:0]     ent_hh, ent_mm;
  logic           key_ok, held, last_digit, range_ok, time_commit, alarm_commit;
  logic           entry_error_q;

  logic [1:0]     ring_state_q, ring_state_d;
  logic [AW-1:0]  alarm_id_q, alarm_id_d, winner;
  logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
  logic [4:0]     snz_hour_q, snz_hour_d;
  logic [5:0]     snz_min_q, snz_min_d;
  logic [6:0]     snz_sum;
  logic           match;

  // Prescaler and timekeeping; a time commit overrides a coincident tick.
  always_comb begin
    period  = fastwatch ? CW'(FAST_TICKS) : CW'(TICKS_PER_MIN);
    tick    = (presc_q == period - CW'(1));
    // >= also clamps a count left out of range by a fastwatch switch.
    presc_d = (presc_q >= period - CW'(1)) ? '0 : presc_q + CW'(1);
    hour_d  = hour_q;
    min_d   = min_q;
    if (time_commit) begin
      presc_d = '0;
      hour_d  = 5'(ent_hh);
      min_d   = 6'(ent_mm);
    end else if (tick) begin
      if (min_q == 6'd59) begin
        min_d  = '0;
        hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
      end else begin
        min_d = min_q + 6'd1;
      end
    end
  end

  // Keypad entry: digits shift in from the right, validated when the fourth arrives.
  always_comb begin
    key_ok       = key_valid && (key <= 4'd9);
    buf_shift    = {buf_q[11:0], key};
    ent_hh       = 7'(buf_shift[15:12]) * 7'd10 + 7'(buf_shift[11:8]);
    ent_mm       = 7'(buf_shift[7:4]) * 7'd10 + 7'(buf_shift[3:0]);
    held         = (ent_state_q == EntTime) ? time_button : alarm_button;
    last_digit   = ((ent_state_q == EntTime) || (ent_state_q == EntAlarm)) && held && key_ok &&
                   (dig_cnt_q == 2'd3);
    range_ok     = (ent_hh <= 7'd23) && (ent_mm <= 7'd59);
    time_commit  = last_digit && range_ok && (ent_state_q == EntTime);
    alarm_commit = last_digit && range_ok && (ent_state_q == EntAlarm);
    ent_state_d  = ent_state_q;
    buf_d        = buf_q;
    dig_cnt_d    = dig_cnt_q;
    ent_sel_d    = ent_sel_q;
    case (ent_state_q)
      EntIdle: begin
        buf_d     = '0;
        dig_cnt_d = '0;
        if (time_button) begin
          ent_state_d = EntTime;
        end else if (alarm_button) begin
          ent_state_d = EntAlarm;
          ent_sel_d   = alarm_sel;
        end
      end
      EntTime, EntAlarm: begin
        if (!held) begin
          ent_state_d = EntIdle;
        end else if (key_ok) begin
          buf_d     = buf_shift;
          dig_cnt_d = dig_cnt_q + 2'd1;
          if (dig_cnt_q == 2'd3) ent_state_d = EntIdle;
        end
      end
      default: ent_state_d = EntIdle;
    endcase
  end

  // Ringing: matches use the time registered on the previous change, so the sound
  // rises one cycle after the display moves.
  always_comb begin
    match  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (!match && alarm_enable[i] && (al_hour_q[i] == hour_q) && (al_min_q[i] == min_q)) begin
        match  = 1'b1;
        winner = AW'(i);
      end
    end
    snz_sum    = 7'(min_q) + 7'(SNOOZE_MIN);
    snz_hour_d = snz_hour_q;
    snz_min_d  = snz_min_q;
    ring_state_d = ring_state_q;
    alarm_id_d   = alarm_id_q;
    ring_cnt_d   = ring_cnt_q;
    case (ring_state_q)
      RingIdle: begin
        if (changed_q && match) begin
          ring_state_d = RingOn;
          alarm_id_d   = winner;
          ring_cnt_d   = '0;
        end
      end
      RingOn: begin
        if (stop_alarm || !alarm_enable[alarm_id_q]) begin
          ring_state_d = RingIdle;
        end else if (snooze) begin
          ring_state_d = RingSnz;
          if (snz_sum >= 7'd60) begin
            snz_min_d  = 6'(snz_sum - 7'd60);
            snz_hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
          end else begin
            snz_min_d  = 6'(snz_sum);
            snz_hour_d = hour_q;
          end
        end else if (tick) begin
          if (ring_cnt_q == RCW'(RING_MIN - 1)) ring_state_d = RingIdle;
          else ring_cnt_d = ring_cnt_q + RCW'(1);
        end
      end
      RingSnz: begin
        if (stop_alarm || !alarm_enable[alarm_id_q]) begin
          ring_state_d = RingIdle;
        end else if (changed_q && (hour_q == snz_hour_q) && (min_q == snz_min_q)) begin
          ring_state_d = RingOn;
          ring_cnt_d   = '0;
        end
      end
      default: ring_state_d = RingIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q       <= '0;
      hour_q        <= '0;
      min_q         <= '0;
      changed_q     <= 1'b0;
      ent_state_q   <= EntIdle;
      buf_q         <= '0;
      dig_cnt_q     <= '0;
      ent_sel_q     <= '0;
      entry_error_q <= 1'b0;
      ring_state_q  <= RingIdle;
      alarm_id_q    <= '0;
      ring_cnt_q    <= '0;
      snz_hour_q    <= '0;
      snz_min_q     <= '0;
      for (int i = 0; i < int'(NUM_ALARMS); i++) begin
        al_hour_q[i] <= '0;
        al_min_q[i]  <= '0;
      end
    end else begin
      presc_q       <= presc_d;
      hour_q        <= hour_d;
      min_q         <= min_d;
      changed_q     <= time_commit || tick;
      ent_state_q   <= ent_state_d;
      buf_q         <= buf_d;
      dig_cnt_q     <= dig_cnt_d;
      ent_sel_q     <= ent_sel_d;
      entry_error_q <= last_digit && !range_ok;
      ring_state_q  <= ring_state_d;
      alarm_id_q    <= alarm_id_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_hour_q    <= snz_hour_d;
      snz_min_q     <= snz_min_d;
      for (int i = 0; i < int'(NUM_ALARMS); i++) begin
        if (alarm_commit && (ent_sel_q == AW'(i))) begin
          al_hour_q[i] <= 5'(ent_hh);
          al_min_q[i]  <= 6'(ent_mm);
        end
      end
    end
  end

  always_comb begin
    if (ent_state_q != EntIdle) begin
      ms_hour   = 8'h30 + {4'h0, buf_q[15:12]};
      ls_hour   = 8'h30 + {4'h0, buf_q[11:8]};
      ms_minute = 8'h30 + {4'h0, buf_q[7:4]};
      ls_minute = 8'h30 + {4'h0, buf_q[3:0]};
    end else begin
      ms_hour   = 8'h30 + 8'(hour_q / 5'd10);
      ls_hour   = 8'h30 + 8'(hour_q % 5'd10);
      ms_minute = 8'h30 + 8'(min_q / 6'd10);
      ls_minute = 8'h30 + 8'(min_q % 6'd10);
    end
    alarm_sound = (ring_state_q == RingOn);
    alarm_id    = alarm_id_q;
    entry_error = entry_error_q;
  end

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
module tb_multi_alarm_clock_core;
  localparam int NA   = 4;
  localparam int TPM  = 8;
  localparam int FT   = 1;
  localparam int SNZ  = 5;
  localparam int RING = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       time_button = 1'b0, alarm_button = 1'b0, fastwatch = 1'b1;
  logic       key_valid = 1'b0, snooze = 1'b0, stop_alarm = 1'b0;
  logic [1:0] alarm_sel = 2'd0;
  logic [3:0] alarm_enable = 4'd0;
  logic [3:0] key = 4'd0;
  logic [7:0] ms_hour, ls_hour, ms_minute, ls_minute;
  logic       alarm_sound, entry_error;
  logic [1:0] alarm_id;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  multi_alarm_clock_core #(
    .NUM_ALARMS(NA), .TICKS_PER_MIN(TPM), .FAST_TICKS(FT), .SNOOZE_MIN(SNZ), .RING_MIN(RING)
  ) dut (
    .clock(clock), .reset(reset), .time_button(time_button), .alarm_button(alarm_button),
    .alarm_sel(alarm_sel), .alarm_enable(alarm_enable), .fastwatch(fastwatch), .key(key),
    .key_valid(key_valid), .snooze(snooze), .stop_alarm(stop_alarm), .ms_hour(ms_hour),
    .ls_hour(ls_hour), .ms_minute(ms_minute), .ls_minute(ls_minute),
    .alarm_sound(alarm_sound), .alarm_id(alarm_id), .entry_error(entry_error)
  );

  // Reference model: time as minute-of-day, entry buffer as a 4-digit decimal number.
  int m_presc, m_time, m_emode, m_buf, m_ndig, m_sel, m_rmode, m_id, m_target, m_rcnt;
  int m_alarm[NA];
  bit m_err, m_chg;

  function automatic void m_reset();
    m_presc = 0; m_time = 0; m_emode = 0; m_buf = 0; m_ndig = 0; m_sel = 0;
    m_rmode = 0; m_id = 0; m_target = 0; m_rcnt = 0; m_err = 0; m_chg = 0;
    for (int i = 0; i < NA; i++) m_alarm[i] = 0;
  endfunction

  function automatic void m_step();
    int p, val, win;
    bit tk, key_ok, held, tcommit, acommit;
    p = fastwatch ? FT : TPM;
    tk = (m_presc == p - 1);
    key_ok = key_valid && (key <= 9);
    tcommit = 0; acommit = 0; val = 0;
    // ringing reacts to the state before this edge
    win = -1;
    for (int i = 0; i < NA; i++)
      if (win < 0 && alarm_enable[i] && m_alarm[i] == m_time) win = i;
    case (m_rmode)
      0: if (m_chg && win >= 0) begin m_rmode = 1; m_id = win; m_rcnt = 0; end
      1: begin
        if (stop_alarm || !alarm_enable[m_id]) m_rmode = 0;
        else if (snooze) begin m_rmode = 2; m_target = (m_time + SNZ) % 1440; end
        else if (tk) begin
          m_rcnt++;
          if (m_rcnt == RING) m_rmode = 0;
        end
      end
      default: begin
        if (stop_alarm || !alarm_enable[m_id]) m_rmode = 0;
        else if (m_chg && m_time == m_target) begin m_rmode = 1; m_rcnt = 0; end
      end
    endcase
    m_err = 0;
    if (m_emode == 0) begin
      m_buf = 0; m_ndig = 0;
      if (time_button) m_emode = 1;
      else if (alarm_button) begin m_emode = 2; m_sel = alarm_sel; end
    end else begin
      held = (m_emode == 1) ? time_button : alarm_button;
      if (!held) m_emode = 0;
      else if (key_ok) begin
        m_buf = (m_buf * 10 + int'(key)) % 10000;
        m_ndig++;
        if (m_ndig == 4) begin
          if (m_buf / 100 <= 23 && m_buf % 100 <= 59) begin
            val = (m_buf / 100) * 60 + m_buf % 100;
            if (m_emode == 1) tcommit = 1; else acommit = 1;
          end else m_err = 1;
          m_emode = 0;
        end
      end
    end
    if (tcommit) begin
      m_time = val; m_presc = 0;
    end else begin
      m_presc = (m_presc >= p - 1) ? 0 : m_presc + 1;
      if (tk) m_time = (m_time + 1) % 1440;
    end
    m_chg = tcommit || tk;
    if (acommit) m_alarm[m_sel] = val;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_reset(); else m_step();
    end
  end

  function automatic logic [31:0] exp_disp();
    int hh, mm;
    if (m_emode != 0) begin hh = m_buf / 100; mm = m_buf % 100; end
    else begin hh = m_time / 60; mm = m_time % 60; end
    return {8'(48 + hh / 10), 8'(48 + hh % 10), 8'(48 + mm / 10), 8'(48 + mm % 10)};
  endfunction

  function automatic logic [31:0] disp();
    return {ms_hour, ls_hour, ms_minute, ls_minute};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("display", disp(), exp_disp());
    check("sound_id", {29'd0, alarm_sound, alarm_id},
          {29'd0, (m_rmode == 1) ? 1'b1 : 1'b0, 2'(m_id)});
    check("entry_error", 32'(entry_error), 32'(m_err));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic press(input int k);
    key = 4'(k); key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic enter_time(input int d0, input int d1, input int d2, input int d3);
    time_button = 1'b1;
    step();
    press(d0); press(d1); press(d2); press(d3);
    time_button = 1'b0;
  endtask

  task automatic enter_alarm(input int sel, input int d0, input int d1, input int d2,
                             input int d3);
    alarm_sel = 2'(sel); alarm_button = 1'b1;
    step();
    press(d0); press(d1); press(d2); press(d3);
    alarm_button = 1'b0;
    step();
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    check("reset_display", disp(), 32'h30303030);
    check("reset_sound", 32'(alarm_sound), 32'd0);
    check("reset_id", 32'(alarm_id), 32'd0);
    repeat (60) step();
    check("fast_60_display", disp(), 32'h30313030);
    check("fast_60_sound", 32'(alarm_sound), 32'd0);

    fastwatch = 1'b0;
    enter_time(2, 3, 5, 9);
    check("set_2359", disp(), 32'h32333539);
    check("set_no_error", 32'(entry_error), 32'd0);
    repeat (8) step();
    check("wrap_0000", disp(), 32'h30303030);

    time_button = 1'b1;
    step();
    press(2); press(4); press(0); press(0);
    check("bad_entry_error", 32'(entry_error), 32'd1);
    time_button = 1'b0;
    step();
    check("bad_entry_pulse_ends", 32'(entry_error), 32'd0);
    time_button = 1'b1;
    step();
    press(1);
    time_button = 1'b0;
    repeat (3) step();

    enter_alarm(2, 0, 0, 0, 3);
    enter_alarm(0, 0, 0, 0, 3);
    enter_time(0, 0, 0, 2);
    alarm_enable = 4'b0101;
    repeat (8) step();
    check("match_latency_quiet", 32'(alarm_sound), 32'd0);
    step();
    check("ring_sound", 32'(alarm_sound), 32'd1);
    check("ring_lowest_id", 32'(alarm_id), 32'd0);
    stop_alarm = 1'b1;
    step();
    stop_alarm = 1'b0;
    check("stop_clears", 32'(alarm_sound), 32'd0);

    enter_time(0, 0, 0, 2);
    repeat (9) step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snoozed_quiet", 32'(alarm_sound), 32'd0);
    for (int i = 0; i < 100 && ls_minute != 8'h38; i++) step();
    check("reach_0008", 32'(ls_minute), 32'h38);
    check("at_0008_quiet", 32'(alarm_sound), 32'd0);
    step();
    check("snooze_rerings", 32'(alarm_sound), 32'd1);
    for (int i = 0; i < 40 && alarm_sound; i++) step();
    check("timeout_at_0010", disp(), 32'h30303130);

    enter_time(0, 0, 0, 2);
    repeat (9) step();
    #1 reset = 1'b0;
    #1;
    check("async_reset_sound", 32'(alarm_sound), 32'd0);
    check("async_reset_display", disp(), 32'h30303030);
    check("async_reset_id", 32'(alarm_id), 32'd0);
    step();
    reset = 1'b1;

    alarm_enable = 4'hF;
    for (int c = 0; c < 5000; c++) begin
      key_valid = 1'b0; snooze = 1'b0; stop_alarm = 1'b0;
      if ($urandom_range(0, 199) == 0) fastwatch = ~fastwatch;
      if ($urandom_range(0, 299) == 0) alarm_enable = 4'($urandom);
      if (!time_button && !alarm_button) begin
        if ($urandom_range(0, 29) == 0) begin
          alarm_sel = 2'($urandom);
          case ($urandom_range(0, 4))
            0: time_button = 1'b1;
            1: begin time_button = 1'b1; alarm_button = 1'b1; end
            default: alarm_button = 1'b1;
          endcase
        end
      end else if ($urandom_range(0, 24) == 0) begin
        time_button = 1'b0; alarm_button = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        key_valid = 1'b1;
        key = 4'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 24) == 0) snooze = 1'b1;
      if ($urandom_range(0, 59) == 0) stop_alarm = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
